// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } fetch_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus; one outstanding request at a time.
interface instruction_fetch_if #(parameter int DW = 32);
    logic          req;
    logic [DW-1:0] addr;
    logic          ack;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, addr, input ack, rvalid, rdata);
    modport slave  (input req, addr, output ack, rvalid, rdata);
endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: clear beats load, otherwise contents hold.
module if_id_register
    import instruction_fetch_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [DW-1:0] i_pc,
    input  logic [DW-1:0] i_instr,
    output logic [DW-1:0] o_pc,
    output logic [DW-1:0] o_instr,
    output logic          o_valid
);

    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_instr;
    logic          r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues word fetches, absorbs decode stalls and execute redirects.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_freeze,
    input  logic                  i_branch_taken,
    input  logic [DATA_WIDTH-1:0] i_branch_addr,
    instruction_fetch_if.master   imem,
    output logic [DATA_WIDTH-1:0] o_pc_out,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic                  o_valid
);

    fetch_state_e          r_state;
    fetch_state_e          w_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_run;

    logic                  w_req;
    logic                  w_ack;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + WORD_BYTES;
    assign w_ack    = imem.ack & w_req;

    // r_run keeps the request low until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (w_ack) w_next = i_branch_taken ? S_DISCARD : S_WAIT;
            S_WAIT: begin
                if (imem.rvalid)
                    w_next = (i_freeze && !i_branch_taken) ? S_HOLD : S_FETCH;
                else if (i_branch_taken)
                    w_next = S_DISCARD;
            end
            S_HOLD:    if (i_branch_taken || !i_freeze) w_next = S_FETCH;
            S_DISCARD: if (imem.rvalid) w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_req       = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_load_data = r_hold;
        case (r_state)
            S_FETCH: w_req = r_run;
            S_WAIT: begin
                w_load_data = imem.rdata;
                w_load      = imem.rvalid & ~i_freeze & ~i_branch_taken;
                w_capture   = imem.rvalid &  i_freeze & ~i_branch_taken;
            end
            S_HOLD:  w_load = ~i_freeze & ~i_branch_taken;
            default: ;
        endcase
    end

    // An unstalled cycle with nothing to load inserts a bubble.
    assign w_clear = i_branch_taken | (~i_freeze & ~w_load);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc   <= word_align(RESET_PC);
            r_hold <= NOP_INSTR;
        end else begin
            if (i_branch_taken)
                r_pc <= word_align(i_branch_addr);
            else if (w_load)
                r_pc <= w_pc_inc;
            if (w_capture)
                r_hold <= imem.rdata;
        end
    end

    assign imem.req  = w_req;
    assign imem.addr = r_pc;

    if_id_register #(.DW(DATA_WIDTH)) u_if_id (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_pc    (w_pc_inc),
        .i_instr (w_load_data),
        .o_pc    (o_pc_out),
        .o_instr (o_instruction),
        .o_valid (o_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed vectors, queued expectations.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        br;
    logic [31:0] baddr;
    logic [31:0] pc_out0, instr0, pc_out1, instr1;
    logic        valid0, valid1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_addr[$];
    logic [63:0] q_ifid[$];
    logic [63:0] exp_ifid;
    logic        mon_pv = 1'b0, mon_pf = 1'b0, mon_pb = 1'b0;

    instruction_fetch_if #(.DW(32)) bus0 ();
    instruction_fetch_if #(.DW(32)) bus1 ();

    always #5 clk = ~clk;

    instruction_fetch dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_freeze(freeze), .i_branch_taken(br),
        .i_branch_addr(baddr), .imem(bus0), .o_pc_out(pc_out0),
        .o_instruction(instr0), .o_valid(valid0)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_freeze(1'b0), .i_branch_taken(1'b0),
        .i_branch_addr(32'h0), .imem(bus1), .o_pc_out(pc_out1),
        .o_instruction(instr1), .o_valid(valid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic ack = 1'b0, input logic rv = 1'b0,
                        input logic [31:0] rd = 32'h0, input logic frz = 1'b0,
                        input logic b = 1'b0, input logic [31:0] ba = 32'h0);
        bus0.ack = ack; bus0.rvalid = rv; bus0.rdata = rd;
        freeze = frz; br = b; baddr = ba;
        @(posedge clk); #1;
    endtask

    // Monitor: accepted fetches and newly loaded IF/ID contents.
    always @(negedge clk) begin
        if (bus0.req && bus0.ack) begin
            if (q_addr.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL fetch_addr: unexpected request addr=%h, none expected", bus0.addr);
            end else
                chk("fetch_addr", bus0.addr, q_addr.pop_front());
        end
        if (valid0 && !(mon_pv && mon_pf && !mon_pb)) begin
            if (q_ifid.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL ifid_unexpected: got pc_out=%h instr=%h, none expected", pc_out0, instr0);
            end else begin
                exp_ifid = q_ifid.pop_front();
                chk("ifid_pc_out", pc_out0, exp_ifid[63:32]);
                chk("ifid_instr", instr0, exp_ifid[31:0]);
            end
        end
        mon_pv = valid0;
        mon_pf = freeze;
        mon_pb = br;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; freeze = 1'b0; br = 1'b0; baddr = 32'h0;
        bus0.ack = 1'b0; bus0.rvalid = 1'b0; bus0.rdata = 32'h0;
        bus1.ack = 1'b0; bus1.rvalid = 1'b0; bus1.rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus0.req), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);
        chk("rst_instr", instr0, 32'h0);
        chk("rst_pc_out", pc_out0, 32'h0);
        chk("rst_addr", bus0.addr, 32'h0);
        rst_n = 1'b1;
        #1 chk("req_before_first_edge", 32'(bus0.req), 32'h0);
        step();
        chk("req_after_release", 32'(bus0.req), 32'h1);

        // zero-wait memory, data = address
        q_addr.push_back(32'h0); q_addr.push_back(32'h4); q_addr.push_back(32'h8);
        q_ifid.push_back({32'h4, 32'h0});
        q_ifid.push_back({32'h8, 32'h4});
        q_ifid.push_back({32'hC, 32'h8});
        step(1); step(0, 1, 32'h0);
        step(1); step(0, 1, 32'h4);
        step(1); step(0, 1, 32'h8);

        // freeze while the response arrives
        q_addr.push_back(32'hC);
        q_ifid.push_back({32'h10, 32'hE3A0_1005});
        step(1);
        step(0, 1, 32'hE3A0_1005, 1);
        chk("frz1_valid", 32'(valid0), 32'h0);
        chk("frz1_req", 32'(bus0.req), 32'h0);
        step(0, 1, 32'hDEAD_BEEF, 1);
        chk("frz2_valid", 32'(valid0), 32'h0);
        step(0, 0, 32'h0, 1);
        chk("frz3_valid", 32'(valid0), 32'h0);
        chk("frz3_instr", instr0, 32'h0);
        chk("frz3_pc_out", pc_out0, 32'h0);
        step();

        // redirect in WAIT, stale response arrives later
        q_addr.push_back(32'h10);
        step(1);
        step(0, 0, 32'h0, 0, 1, 32'h0000_0103);
        chk("discard_req", 32'(bus0.req), 32'h0);
        chk("discard_valid", 32'(valid0), 32'h0);
        step(0, 1, 32'hBAD0_0000);
        chk("stale_valid", 32'(valid0), 32'h0);
        chk("redir_addr", bus0.addr, 32'h0000_0100);
        q_addr.push_back(32'h100);
        q_ifid.push_back({32'h104, 32'h1111_1111});
        step(1); step(0, 1, 32'h1111_1111);

        // redirect plus freeze while holding a buffered instruction
        q_addr.push_back(32'h104);
        step(1);
        step(0, 1, 32'h2222_2222, 1);
        step(0, 0, 32'h0, 1, 1, 32'h200);
        chk("hold_redir_valid", 32'(valid0), 32'h0);
        chk("hold_redir_req", 32'(bus0.req), 32'h1);
        chk("hold_redir_addr", bus0.addr, 32'h200);
        q_addr.push_back(32'h200);
        q_ifid.push_back({32'h204, 32'h3333_3333});
        step(1); step(0, 1, 32'h3333_3333);

        // redirect in FETCH with and without ack, and in WAIT with rvalid
        q_addr.push_back(32'h204);
        step(1, 0, 32'h0, 0, 1, 32'h400);
        chk("fetch_ack_redir_req", 32'(bus0.req), 32'h0);
        chk("fetch_ack_redir_valid", 32'(valid0), 32'h0);
        step(0, 0, 32'h0, 0, 1, 32'h480);
        chk("discard_redir_req", 32'(bus0.req), 32'h0);
        step(0, 1, 32'h4444_4444);
        chk("discard_drop_valid", 32'(valid0), 32'h0);
        chk("discard_redir_addr", bus0.addr, 32'h480);
        step(0, 0, 32'h0, 0, 1, 32'h502);
        chk("fetch_redir_addr", bus0.addr, 32'h500);
        chk("fetch_redir_req", 32'(bus0.req), 32'h1);
        q_addr.push_back(32'h500);
        step(1);
        step(0, 1, 32'h5555_5555, 0, 1, 32'h600);
        chk("wait_rv_redir_valid", 32'(valid0), 32'h0);
        chk("wait_rv_redir_addr", bus0.addr, 32'h600);

        // freeze holds a valid IF/ID, release produces a bubble
        q_addr.push_back(32'h600);
        q_ifid.push_back({32'h604, 32'h6666_6666});
        step(1); step(0, 1, 32'h6666_6666);
        step(0, 0, 32'h0, 1);
        chk("held_valid", 32'(valid0), 32'h1);
        chk("held_instr", instr0, 32'h6666_6666);
        chk("held_pc_out", pc_out0, 32'h604);
        step();
        chk("bubble_valid", 32'(valid0), 32'h0);
        chk("bubble_instr", instr0, 32'h0);

        // reset while waiting, stray response after release
        q_addr.push_back(32'h604);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus0.req), 32'h0);
        chk("async_rst_addr", bus0.addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 1, 32'h7777_7777);
        chk("stray_valid", 32'(valid0), 32'h0);
        chk("post_rst_req", 32'(bus0.req), 32'h1);
        chk("post_rst_addr", bus0.addr, 32'h0);
        q_addr.push_back(32'h0);
        q_ifid.push_back({32'h4, 32'h8888_8888});
        step(1); step(0, 1, 32'h8888_8888);
        step();

        // PC wrap from the top of the address space
        chk("wrap_first_addr", bus1.addr, 32'hFFFF_FFFC);
        bus1.ack = 1'b1;
        @(posedge clk); #1;
        bus1.ack = 1'b0; bus1.rvalid = 1'b1; bus1.rdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        bus1.rvalid = 1'b0;
        chk("wrap_valid", 32'(valid1), 32'h1);
        chk("wrap_pc_out", pc_out1, 32'h0);
        chk("wrap_instr", instr1, 32'hCAFE_0001);
        chk("wrap_second_addr", bus1.addr, 32'h0);
        step();

        chk("addr_queue_empty", 32'(q_addr.size()), 32'h0);
        chk("ifid_queue_empty", 32'(q_ifid.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 Parameter: DATA_WIDTH, 32, instruction/address width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 freeze  input  1  hazard stall from decode; hold PC and IF/ID outputs.
REQ-006 branch_taken  input  1  redirect request from execute; implies flush.
REQ-007 branch_addr  input  32  redirect target.
REQ-008 imem_req  output  1  fetch request valid.
REQ-009 imem_addr  output  32  fetch word address (bits [1:0] always 0).
REQ-010 imem_ack  input  1  memory accepted request this cycle.
REQ-011 imem_rvalid  input  1  response data valid; at most one outstanding request.
REQ-012 imem_rdata  input  32  fetched instruction.
REQ-013 pc_out  output  32  address of held instruction + 4, registered (IF/ID).
REQ-014 instruction  output  32  registered instruction to decode (IF/ID).
REQ-015 valid  output  1  IF/ID holds a real instruction.

Function
REQ-016 States: FETCH, WAIT, HOLD, DISCARD.
REQ-017 FETCH: imem_req=1, imem_addr=pc; imem_ack -> WAIT; otherwise stay.
REQ-018 WAIT: imem_req=0; on imem_rvalid with freeze=0, load IF/ID {pc+4, imem_rdata, valid=1}, pc<=pc+4, -> FETCH.
REQ-019 WAIT: on imem_rvalid with freeze=1, capture imem_rdata in hold buffer, IF/ID unchanged, -> HOLD.
REQ-020 HOLD: imem_req=0; first cycle freeze=0, load IF/ID from hold buffer, pc<=pc+4, -> FETCH.
REQ-021 With freeze=1 and no redirect, pc, IF/ID registers and hold buffer do not change.
REQ-022 branch_taken=1 (any state, overrides freeze): pc<=branch_addr with bits [1:0] cleared; IF/ID cleared (valid=0, instruction=0, pc_out=0).
REQ-023 Redirect in FETCH with imem_ack same cycle -> DISCARD; without ack -> stay FETCH, next imem_addr = new pc.
REQ-024 Redirect in WAIT: rvalid same cycle -> data dropped, -> FETCH; else -> DISCARD.
REQ-025 Redirect in HOLD: hold buffer dropped, -> FETCH.
REQ-026 DISCARD: imem_req=0; next imem_rvalid dropped, -> FETCH; further redirects update pc only.
REQ-027 imem_rvalid in FETCH or HOLD is ignored.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 Minimum latency: request accepted cycle N, rvalid cycle N+1 -> valid high from cycle N+2; back-to-back throughput one instruction per 2 cycles with zero-wait memory.
REQ-030 valid deasserts after one cycle of IF/ID update without a new instruction: when freeze=0 and no load occurs, IF/ID cleared (bubble).

Reset
REQ-031 rst low: immediately state=FETCH, pc=RESET_PC, hold buffer=0, pc_out=0, instruction=0, valid=0.
REQ-032 imem_req=0 while rst is low; asserted from the first clock edge after release.
REQ-033 Reset mid-transaction abandons outstanding request; later stray rvalid ignored per REQ-027.

Structure
REQ-034 Shared package instruction_fetch_pkg holds state enum, WORD_BYTES=4, NOP_INSTR=32'h0.
REQ-035 One sub-module, if_id_register: IF/ID pipeline register with load, clear and async active-low reset.

Verification
REQ-036 Reset release, zero-wait memory returning addr-as-data -> imem_addr 0,4,8; instruction 0,4,8; pc_out 4,8,12.
REQ-037 freeze high 3 cycles while WAIT gets rvalid=32'hE3A0_1005 -> outputs frozen; after release instruction=32'hE3A0_1005, valid=1.
REQ-038 branch_taken to 32'h0000_0103 in WAIT, stale rvalid one cycle later -> stale data never reaches valid; next imem_addr=32'h0000_0100.
REQ-039 branch_taken and freeze both high in HOLD -> buffer dropped, valid=0, next imem_addr=branch target.
REQ-040 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-041 rst low while in WAIT, rvalid after release -> ignored; first accepted fetch address RESET_PC.
